// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions, exception codes
// and word-packing helpers used by cp0_unit.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int unsigned ST_IE      = 0;
    localparam int unsigned ST_EXL     = 1;
    localparam int unsigned ST_IM_LSB  = 8;
    localparam int unsigned CA_EXC_LSB = 2;
    localparam int unsigned CA_IP_LSB  = 8;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8
    } exc_code_e;

    function automatic logic [31:0] status_word(input logic ie, input logic exl,
                                                input logic [7:0] im);
        logic [31:0] w;
        w = '0;
        w[ST_IE] = ie;
        w[ST_EXL] = exl;
        w[ST_IM_LSB +: 8] = im;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input logic [7:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[CA_IP_LSB +: 8] = ip;
        w[CA_EXC_LSB +: 5] = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: free-running Count with MTC0 load, Compare register and a sticky
// timer_pending flag cleared only by a Compare write.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               count_we_i,
    input  logic               compare_we_i,
    input  logic [COUNT_W-1:0] wdata_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [COUNT_W-1:0] compare_o,
    output logic               timer_pending_o
);

    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] compare_q, compare_d;
    logic               pending_q, pending_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + COUNT_W'(1);
        compare_d = compare_we_i ? wdata_i : compare_q;
        // Match is against the value Count takes this edge, so pending shows with that value.
        pending_d = compare_we_i ? 1'b0 : (pending_q | (count_d == compare_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count_o         = count_q;
    assign compare_o       = compare_q;
    assign timer_pending_o = pending_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC state, interrupt request, exception entry/eret and
// MTC0/MFC0 access. Define CP0_TIMER_EN to include the Count/Compare timer.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_stall,
    input  logic        cu_cp0_w_en,
    input  logic [4:0]  cu_exec_code,
    input  logic [31:0] cu_epc,
    input  logic        exmem_eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  hw_intr,
    output logic [31:0] cp0_rdata,
    output logic        cp0_intr,
    output logic [31:0] cp0_epc
);

    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [7:0]  im_q, im_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  hw_q;

    logic               entry_commit, eret_commit, mtc0_commit;
    logic [COUNT_W-1:0] count_val, compare_val;
    logic               timer_pending;
    logic [7:0]         ip;

    assign entry_commit = cu_cp0_w_en & ~mem_stall;
    assign eret_commit  = exmem_eret & ~mem_stall;
    assign mtc0_commit  = mtc0_we & ~mem_stall;

`ifdef CP0_TIMER_EN
    logic count_we, compare_we;
    assign count_we   = mtc0_commit & (cp0_addr == CP0_COUNT);
    assign compare_we = mtc0_commit & (cp0_addr == CP0_COMPARE);

    cp0_timer #(
        .COUNT_W(COUNT_W)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .count_we_i     (count_we),
        .compare_we_i   (compare_we),
        .wdata_i        (cp0_wdata[COUNT_W-1:0]),
        .count_o        (count_val),
        .compare_o      (compare_val),
        .timer_pending_o(timer_pending)
    );
`else
    assign count_val     = '0;
    assign compare_val   = '0;
    assign timer_pending = 1'b0;
`endif

    assign ip = {hw_q[5] | timer_pending, hw_q[4:0], ip_sw_q};

    // Later assignments win: MTC0 first, then eret, then exception entry.
    always_comb begin
        ie_d    = ie_q;
        exl_d   = exl_q;
        im_d    = im_q;
        ip_sw_d = ip_sw_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        if (mtc0_commit) begin
            case (cp0_addr)
                CP0_STATUS: begin
                    ie_d  = cp0_wdata[ST_IE];
                    exl_d = cp0_wdata[ST_EXL];
                    im_d  = cp0_wdata[ST_IM_LSB +: 8];
                end
                CP0_CAUSE: ip_sw_d = cp0_wdata[CA_IP_LSB +: 2];
                CP0_EPC:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end
        if (eret_commit) begin
            exl_d = 1'b0;
        end
        if (entry_commit) begin
            exl_d = 1'b1;
            exc_d = cu_exec_code;
            epc_d = cu_epc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            im_q    <= '0;
            ip_sw_q <= '0;
            exc_q   <= EXC_INT;
            epc_q   <= '0;
            hw_q    <= '0;
        end else begin
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            im_q    <= im_d;
            ip_sw_q <= ip_sw_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            hw_q    <= hw_intr;
        end
    end

    always_comb begin
        case (cp0_addr)
            CP0_COUNT:   cp0_rdata = 32'(count_val);
            CP0_COMPARE: cp0_rdata = 32'(compare_val);
            CP0_STATUS:  cp0_rdata = status_word(ie_q, exl_q, im_q);
            CP0_CAUSE:   cp0_rdata = cause_word(ip, exc_q);
            CP0_EPC:     cp0_rdata = epc_q;
            default:     cp0_rdata = '0;
        endcase
    end

    assign cp0_intr = ie_q & ~exl_q & (|(ip & im_q));
    assign cp0_epc  = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Randomized self-checking bench for cp0_unit against a behavioural CP0 model.
// Honours CP0_TIMER_EN the same way as the design.
module tb_cp0_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_stall;
    logic        cu_cp0_w_en;
    logic [4:0]  cu_exec_code;
    logic [31:0] cu_epc;
    logic        exmem_eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [5:0]  hw_intr;
    logic [31:0] cp0_rdata;
    logic        cp0_intr;
    logic [31:0] cp0_epc;

    int n_vec = 0;
    int n_err = 0;

    cp0_unit #(
        .COUNT_W(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_stall   (mem_stall),
        .cu_cp0_w_en (cu_cp0_w_en),
        .cu_exec_code(cu_exec_code),
        .cu_epc      (cu_epc),
        .exmem_eret  (exmem_eret),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .hw_intr     (hw_intr),
        .cp0_rdata   (cp0_rdata),
        .cp0_intr    (cp0_intr),
        .cp0_epc     (cp0_epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_ie, m_exl, m_pend;
    bit   [7:0]  m_im;
    bit   [1:0]  m_ipsw;
    bit   [5:0]  m_hw;
    bit   [4:0]  m_exc;
    bit   [31:0] m_epc, m_count, m_compare;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_pend = 0; m_im = 0; m_ipsw = 0; m_hw = 0; m_exc = 0;
        m_epc = 0; m_count = 0; m_compare = 0;
    endtask

    function automatic bit [7:0] m_ip();
        return {m_hw[5] | m_pend, m_hw[4:0], m_ipsw};
    endfunction

    function automatic bit m_intr();
        return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
    endfunction

    function automatic bit [31:0] m_rdata(input bit [4:0] a);
        case (a)
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return 32'(m_im) * 256 + 32'(m_exl) * 2 + 32'(m_ie);
            5'd13: return 32'(m_ip()) * 256 + 32'(m_exc) * 4;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit stall, input bit en, input bit [4:0] code,
                              input bit [31:0] epc, input bit eret, input bit we,
                              input bit [4:0] a, input bit [31:0] wd, input bit [5:0] hw);
        bit [31:0] cnt_next;
        bit        cmp_w;
        cnt_next = m_count + 1;
        cmp_w    = !stall && we && a == 5'd11;
        if (!stall && we) begin
            if (a == 5'd12) begin
                m_ie = wd[0]; m_exl = wd[1]; m_im = wd[15:8];
            end
            if (a == 5'd13) m_ipsw = wd[9:8];
            if (a == 5'd14) m_epc = wd;
            if (a == 5'd9) cnt_next = wd;
        end
        if (!stall && eret) m_exl = 0;
        if (!stall && en) begin
            m_exl = 1; m_exc = code; m_epc = epc;
        end
`ifdef CP0_TIMER_EN
        m_pend  = cmp_w ? 1'b0 : (m_pend || cnt_next == m_compare);
        m_count = cnt_next;
        if (cmp_w) m_compare = wd;
`endif
        m_hw = hw;
    endtask

    // Compare outputs mid-cycle, then clock one edge into both DUT and model.
    task automatic step();
        @(negedge clk);
        check("rdata", cp0_rdata, m_rdata(cp0_addr));
        check("intr", {31'd0, cp0_intr}, {31'd0, m_intr()});
        check("epc", cp0_epc, m_epc);
        @(posedge clk);
        model_edge(mem_stall, cu_cp0_w_en, cu_exec_code, cu_epc, exmem_eret, mtc0_we,
                   cp0_addr, cp0_wdata, hw_intr);
        #1;
    endtask

    task automatic idle();
        mem_stall = 0; cu_cp0_w_en = 0; cu_exec_code = 0; cu_epc = 0; exmem_eret = 0;
        mtc0_we = 0; cp0_wdata = 0;
    endtask

    task automatic peek(input logic [4:0] a);
        cp0_addr = a;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
        step();
    endtask

    initial begin
        rst_n = 0;
        idle();
        hw_intr = 0;
        cp0_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        foreach (dut.cp0_rdata[i]) if (i < 5) begin
            peek(5'(9 + i));
            check("rst_rdata", cp0_rdata, 32'd0);
        end
        check("rst_intr", {31'd0, cp0_intr}, 32'd0);
        check("rst_epc", cp0_epc, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // hw_intr[0] -> IP[2], enabled via IM[10]
        hw_intr = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        idle();
        peek(5'd13);
        check("hw_cause", cp0_rdata, 32'h0000_0400);
        check("hw_intr", {31'd0, cp0_intr}, 32'd1);

        // Interrupt entry then eret
        cu_cp0_w_en = 1; cu_exec_code = 5'd0; cu_epc = 32'h8000_0040;
        step();
        idle();
        peek(5'd14);
        check("ent_epc_rd", cp0_rdata, 32'h8000_0040);
        check("ent_epc", cp0_epc, 32'h8000_0040);
        check("ent_intr", {31'd0, cp0_intr}, 32'd0);
        peek(5'd12);
        check("ent_status", cp0_rdata, 32'h0000_0403);
        exmem_eret = 1;
        step();
        idle();
        peek(5'd12);
        check("eret_status", cp0_rdata, 32'h0000_0401);
        check("eret_intr", {31'd0, cp0_intr}, 32'd1);

        // Stalled syscall entry
        cu_cp0_w_en = 1; cu_exec_code = 5'd8; cu_epc = 32'h0000_1234; mem_stall = 1;
        cp0_addr = 5'd13;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_cause", cp0_rdata, 32'h0000_0400);
        end
        mem_stall = 0;
        step();
        idle();
        peek(5'd13);
        check("sys_cause", cp0_rdata, 32'h0000_0420);
        check("sys_epc", cp0_epc, 32'h0000_1234);
        exmem_eret = 1;
        step();

        // Entry beats same-cycle MTC0 EPC
        idle();
        cu_cp0_w_en = 1; cu_epc = 32'h100; mtc0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h200;
        step();
        idle();
        check("prio_epc", cp0_epc, 32'h0000_0100);
        exmem_eret = 1;
        step();
        hw_intr = 0;

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'h0000_0001);
        mtc0(5'd9, 32'hFFFF_FFFE);
        mtc0(5'd12, 32'h0000_8001);
        idle();
        cp0_addr = 5'd9;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cp0_intr) break;
            step();
        end
        peek(5'd9);
        check("tmr_intr", {31'd0, cp0_intr}, 32'd1);
        check("tmr_count", cp0_rdata, 32'd1);
        mtc0(5'd11, 32'h0000_1000);
        idle();
        #1;
        check("tmr_clear", {31'd0, cp0_intr}, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            mem_stall    = ($urandom_range(3) == 0);
            cu_cp0_w_en  = ($urandom_range(7) == 0);
            cu_exec_code = ($urandom_range(1) == 0) ? 5'd0 : 5'd8;
            cu_epc       = $urandom;
            exmem_eret   = ($urandom_range(4) == 0);
            mtc0_we      = ($urandom_range(2) == 0);
            case ($urandom_range(6))
                0: cp0_addr = 5'd9;
                1: cp0_addr = 5'd11;
                2, 3: cp0_addr = 5'd12;
                4: cp0_addr = 5'd13;
                5: cp0_addr = 5'd14;
                default: cp0_addr = 5'($urandom);
            endcase
            cp0_wdata = $urandom;
            if (cp0_addr == 5'd11 && $urandom_range(1) == 1)
                cp0_wdata = m_count + 32'($urandom_range(4));
            if (cp0_addr == 5'd12 && $urandom_range(1) == 1) begin
                cp0_wdata[0] = 1'b1;
                cp0_wdata[1] = 1'b0;
            end
            if ($urandom_range(7) == 0) hw_intr = 6'($urandom);
            step();
        end

        // Asynchronous reset mid-operation
        mtc0(5'd14, 32'hDEAD_BEEF);
        hw_intr = 6'h3F;
        mtc0(5'd12, 32'h0000_FF01);
        idle();
        step();
        rst_n = 0;
        model_reset();
        #1;
        check("arst_intr", {31'd0, cp0_intr}, 32'd0);
        check("arst_epc", cp0_epc, 32'd0);
        for (int a = 9; a <= 14; a++) begin
            cp0_addr = 5'(a);
            #0.5;
            check("arst_rdata", cp0_rdata, 32'd0);
        end
        hw_intr = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        cp0_addr = 5'd9;
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 responder for the five-stage MIPS pipeline. Holds Status, Cause, EPC, Count and Compare. Samples hardware and timer interrupt sources and raises `cp0_intr` to the pipeline control unit. Commits exception entry (`cu_cp0_w_en`/`cu_exec_code`/`cu_epc`) and `eret` return, and serves MTC0/MFC0 register access from the EX/MEM stage.

## Interface
Parameters:
- `COUNT_W`, 32, width of Count/Compare.

Ports (clock and reset first):
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_stall` in 1: memory stall; gates every state commit except Count.
- `cu_cp0_w_en` in 1: exception entry request from control unit.
- `cu_exec_code` in 5: ExcCode for entry (0 = Int, 8 = Sys).
- `cu_epc` in 32: return address for entry.
- `exmem_eret` in 1: eret at EX/MEM.
- `mtc0_we` in 1: MTC0 write strobe.
- `cp0_addr` in 5: register number for read/write.
- `cp0_wdata` in 32: MTC0 data.
- `hw_intr` in 6: external interrupt lines, level-sensitive.
- `cp0_rdata` out 32: MFC0 data, combinational from `cp0_addr`.
- `cp0_intr` out 1: interrupt request to control unit.
- `cp0_epc` out 32: EPC register, eret target.

## Operation
- Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Unmapped reads return 0; unmapped writes are ignored.
- Status fields: IE[0], EXL[1], IM[15:8]. All other bits read 0.
- Cause fields: IP[15:8], ExcCode[6:2]. All other bits read 0.
- Cause bit mapping:
  - IP[1:0] are software-writable.
  - IP[6:2] are registered copies of `hw_intr[4:0]`.
  - IP[7] = registered `hw_intr[5]` OR timer_pending.
- Interrupt request: `cp0_intr` = IE & ~EXL & |(IP & IM). Combinational from registered state only. No path from `cu_cp0_w_en`, `exmem_eret` or `mtc0_we`.
- Exception entry (`cu_cp0_w_en` & ~`mem_stall`): EXL←1, ExcCode←`cu_exec_code`, EPC←`cu_epc`.
- eret (`exmem_eret` & ~`mem_stall`): EXL←0.
- MTC0 (`mtc0_we` & ~`mem_stall`): writes writable fields of the addressed register.
  - Write to Compare clears timer_pending.
  - Write to Count loads `cp0_wdata` and suppresses that cycle's increment.
- Same-cycle priority on Status/Cause/EPC: entry > eret > MTC0. A lower-priority write to a field also touched by a higher one is dropped. MTC0 to Count/Compare still proceeds alongside entry/eret.
- Timer:
  - Count increments by 1 every cycle, including during `mem_stall`, wrapping modulo 2^COUNT_W.
  - timer_pending sets in the cycle after Count's next value equals Compare.
  - timer_pending stays set until Compare is written.
- Reset values (all zero):
  - Status = 0, Cause = 0, EPC = 0, Count = 0, Compare = 0, timer_pending = 0, sampled `hw_intr` = 0.
  - Outputs: `cp0_intr` = 0, `cp0_epc` = 0, `cp0_rdata` = 0 for the reset address.

## Timing
- `hw_intr` → IP: 1 cycle. IP → `cp0_intr`: 0 cycles. Overall, `hw_intr` → `cp0_intr` is 1 cycle.
- Entry commits on the clock edge. EXL=1 drops `cp0_intr` the next cycle, so the control unit sees a single-cycle request per entry.
- MTC0 write is visible on `cp0_rdata`/`cp0_epc` the cycle after commit. There is no same-cycle bypass.
- eret commits on the edge. `cp0_intr` may reassert the following cycle if a request is still pending.
- A stalled entry, eret or MTC0 (`mem_stall`=1) has no effect. The control unit keeps it asserted until the stall clears.
- Reset asserted mid-operation clears all state asynchronously. Count restarts from 0 on the first edge after release.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count/Compare and timer_pending are implemented.
  - IP[7] includes timer_pending.
- `CP0_TIMER_EN` undefined:
  - Count/Compare are absent and read 0.
  - Writes to them are ignored.
  - IP[7] = registered `hw_intr[5]` only.

## Structure
- Shared package `cp0_pkg` holds:
  - register numbers (`CP0_COUNT`, `CP0_COMPARE`, `CP0_STATUS`, `CP0_CAUSE`, `CP0_EPC`);
  - Status/Cause bit positions;
  - ExcCode constants (`EXC_INT`=0, `EXC_SYS`=8).
- One sub-module, `cp0_timer`, holds Count, Compare and timer_pending. Its inputs are the load/compare-write strobes; its output is `timer_pending`. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset, then MTC0 Status=0x0000_0401 (IE=1, IM[10]), drive `hw_intr`=6'b000001 → `cp0_intr`=1 one cycle later. Cause reads 0x0000_0400.
- With `cp0_intr`=1, assert `cu_cp0_w_en`, `cu_exec_code`=0, `cu_epc`=0x8000_0040 for one cycle → next cycle EPC=0x8000_0040, Status[1]=1, `cp0_intr`=0. Then `exmem_eret` → EXL=0 and `cp0_intr`=1 again.
- Syscall entry (`cu_exec_code`=8) while `mem_stall`=1 for 3 cycles → no change. On the release cycle, Cause[6:2]=8.
- Same-cycle `cu_cp0_w_en` (EPC 0x100) and MTC0 EPC=0x200 → EPC=0x100.
- `CP0_TIMER_EN`: MTC0 Count=0xFFFF_FFFE, Compare=0x0000_0001, IM[15]=1, IE=1 → Count wraps through 0. `cp0_intr` rises once Count reaches 1. Writing Compare clears it.
- Assert `rst_n`=0 mid-count → all registers read 0 and `cp0_intr`=0 immediately, with no clock edge needed.
